alarm_countdown: RTL
====================

Name: alarm_countdown

Overview:
- Countdown timer for the anti-theft alarm. It answers the start/expired handshake driven by the alarm control FSM.
- It loads a 4-bit seconds value from the time-parameter store and signals expiry after exactly that many seconds.
- It also provides free-running 1 Hz and 0.5 Hz enables for the status-LED blink and other second-based logic.
- Sits between time_parameters (value source) and the top-level FSMs (start_timer initiator, expired consumer).

Parameters:
- CLK_HZ, 4: clock cycles per second. Minimum 2. Board build overrides it with the real clock frequency; 4 is used for simulation.
- CNT_W, 24: prescaler counter width. Must satisfy 2^CNT_W >= CLK_HZ.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start_timer  in  1  start request. Only the 0->1 transition is significant.
- value  in  4  countdown length in seconds (0..15). Sampled only on a start event.
- expired  out  1  level. High while in DONE.
- busy  out  1  level. High while in COUNT.
- remaining  out  4  seconds left, for debug/display.
- one_hz_enable  out  1  one-cycle pulse, once every CLK_HZ cycles, free-running.
- half_hz_enable  out  1  square wave, toggles on each one_hz_enable pulse (period 2 s).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; prescaler=0; phase=0; remaining=0; start_d=0.
  - expired=0, busy=0, one_hz_enable=0, half_hz_enable=0.
  - Outputs stay at these values until the first clock edge after reset returns to 1.
- Start event:
  - start_ev = start_timer & ~start_d, where start_d is start_timer registered each cycle.
  - A level held high produces exactly one start event.
- Free-running prescaler:
  - Counts 0..CLK_HZ-1 and wraps; independent of the countdown.
  - one_hz_enable=1 in the cycle the prescaler equals CLK_HZ-1.
  - half_hz_enable toggles on the edge where one_hz_enable=1.
- Countdown has its own phase counter, so timing is aligned to the start event, not to the prescaler.
- States: IDLE, COUNT, DONE.
  - Any state, start_ev with value=N>0: at that edge go to COUNT, remaining=N, phase=0.
  - Any state, start_ev with value=0: at that edge go to DONE, remaining=0. Zero-length countdown; expired is visible the cycle after the start edge.
  - COUNT, no start_ev: phase increments each edge. When phase==CLK_HZ-1: phase=0 and remaining decrements. If remaining was 1, go to DONE.
  - DONE, no start_ev: remain in DONE while start_timer=1; go to IDLE on the edge where start_timer=0.
  - IDLE, no start_ev: hold; remaining holds 0.
- Latency: start sampled at edge k with value=N gives expired=1 after edge k+N*CLK_HZ. Total is exactly N*CLK_HZ cycles, with no off-by-one.
- Retrigger: start_ev while in COUNT or DONE reloads from the current value. Phase restarts and expired drops at that edge.
- value changes outside a start event are ignored; the captured count is used.
- Simultaneous events:
  - start_ev on the same edge as a terminal decrement: start_ev wins, the countdown reloads, and expired is not asserted.
  - start_ev on the same edge as start_timer falling in DONE: cannot occur, since start_ev requires start_timer=1.
- Reset asserted mid-COUNT: immediate return to IDLE with outputs cleared. No expiry is reported afterwards.
- Arithmetic:
  - remaining is unsigned 4-bit and never decrements below 0.
  - prescaler and phase compare against CLK_HZ-1 as unsigned CNT_W-bit values.
- busy = (state==COUNT) and expired = (state==DONE), both registered state decodes. They are never high together.

Test Plan:
- Reset mid-count (CLK_HZ=4): value=3, pulse start, release reset=0 after 5 cycles -> all outputs 0 immediately. Reset high 20 cycles -> expired stays 0.
- Basic countdown: value=3, start_timer 0->1 held -> busy=1 for 12 cycles; remaining steps 3,2,1 every 4 cycles; expired=1 exactly 12 cycles after the start edge and held. Drop start_timer -> expired=0 next edge, state IDLE.
- Zero value: value=0, start rising -> expired=1 one cycle later; busy never asserts.
- Retrigger: value=5, start; after 9 cycles pulse start again with value=2 -> expired asserts 8 cycles after the second edge; no expiry at the original cycle 20.
- Value change ignored: value=4, start, then set value=15 one cycle later -> expiry still at 16 cycles.
- Enables: run 40 cycles after reset -> one_hz_enable pulses at cycles 4,8,...,40 (10 pulses, each 1 cycle wide); half_hz_enable toggles on each pulse (5 high/low periods of 4 cycles each); both unaffected by start/expiry activity.

Source files
------------

// File: rtl/alarm_countdown_if.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_countdown_if
//  Brief    : Start/expired handshake between alarm control FSM and timer.
//  Revision : 1.0 - initial release
// ============================================================================
interface alarm_countdown_if;
  logic       start_timer;
  logic [3:0] value;
  logic       expired;
  logic       busy;
  logic [3:0] remaining;

  modport master (
    output start_timer,
    output value,
    input  expired,
    input  busy,
    input  remaining
  );

  modport slave (
    input  start_timer,
    input  value,
    output expired,
    output busy,
    output remaining
  );
endinterface
`default_nettype wire

// File: rtl/alarm_countdown.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_countdown
//  Brief    : Start-aligned seconds countdown plus free-running 1 Hz / 0.5 Hz enables.
//  Revision : 1.0 - initial release
// ============================================================================
module alarm_countdown #(
  parameter int CLK_HZ = 4,
  parameter int CNT_W  = 24
) (
  input  logic              clock,
  input  logic              reset,
  alarm_countdown_if.slave  tmr,
  output logic              one_hz_enable,
  output logic              half_hz_enable
);

  localparam logic [1:0]       c_IDLE  = 2'd0;
  localparam logic [1:0]       c_COUNT = 2'd1;
  localparam logic [1:0]       c_DONE  = 2'd2;
  localparam logic [CNT_W-1:0] c_LAST  = CNT_W'(CLK_HZ - 1);

  logic             r_start_d;
  logic [CNT_W-1:0] r_prescaler;
  logic             r_half;
  logic [CNT_W-1:0] r_phase;
  logic [1:0]       r_state;
  logic [3:0]       r_remaining;
  logic             w_start_ev;
  logic             w_tick;

  assign w_start_ev = tmr.start_timer & ~r_start_d;
  assign w_tick     = (r_prescaler == c_LAST);

  assign one_hz_enable  = w_tick;
  assign half_hz_enable = r_half;
  assign tmr.busy       = (r_state == c_COUNT);
  assign tmr.expired    = (r_state == c_DONE);
  assign tmr.remaining  = r_remaining;

  // Prescaler is free-running and never touched by the countdown.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prescaler <= '0;
      r_half      <= 1'b0;
    end else if (w_tick) begin
      r_prescaler <= '0;
      r_half      <= ~r_half;
    end else begin
      r_prescaler <= r_prescaler + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_start_d   <= 1'b0;
      r_state     <= c_IDLE;
      r_phase     <= '0;
      r_remaining <= 4'd0;
    end else begin
      r_start_d <= tmr.start_timer;
      if (w_start_ev) begin
        // A start always wins, including over a terminal decrement.
        r_phase     <= '0;
        r_remaining <= tmr.value;
        r_state     <= (tmr.value == 4'd0) ? c_DONE : c_COUNT;
      end else begin
        case (r_state)
          c_COUNT: begin
            if (r_phase == c_LAST) begin
              r_phase <= '0;
              if (r_remaining != 4'd0) begin
                r_remaining <= r_remaining - 4'd1;
              end
              if (r_remaining <= 4'd1) begin
                r_state <= c_DONE;
              end
            end else begin
              r_phase <= r_phase + CNT_W'(1);
            end
          end
          c_DONE: begin
            if (!tmr.start_timer) begin
              r_state <= c_IDLE;
            end
          end
          default: begin
            r_state     <= c_IDLE;
            r_remaining <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
